// File: rtl/core_run_ctrl.sv
// Run controller for a test core: holds the core in reset, lets it run, and
// watches tohost writes and a cycle budget to decide pass, fail or timeout.
module core_run_ctrl #(
  parameter int unsigned         RST_CYCLES     = 2,
  parameter int unsigned         TIMEOUT_CYCLES = 100000,
  parameter int unsigned         ADDR_W         = 32,
  parameter int unsigned         DATA_W         = 32,
  parameter int unsigned         CNT_W          = 32,
  parameter logic [ADDR_W-1:0]   TOHOST_ADDR    = ADDR_W'(32'h0000_1000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              restart_i,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              retire_i,
  output logic              core_rst_o,
  output logic              running_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] fail_code_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  instret_cnt_o
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [63:0]      TO_LAST  = 64'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            state_q, state_d;
  logic [7:0]        rstCnt_q, rstCnt_d;
  logic [CNT_W-1:0]  cycleCnt_q, cycleCnt_d;
  logic [CNT_W-1:0]  instretCnt_q, instretCnt_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] failCode_q, failCode_d;

  logic inRun, tohostHit, passHit, failHit, timeoutHit;

  // Zero-extended compare so a budget wider than the counter simply never fires.
  assign inRun      = (state_q == ST_RUN);
  assign tohostHit  = inRun && wr_valid_i && (wr_addr_i == TOHOST_ADDR);
  assign passHit    = tohostHit && (wr_data_i == DATA_W'(1));
  assign failHit    = tohostHit && (wr_data_i > DATA_W'(1));
  assign timeoutHit = inRun && !passHit && !failHit && (64'(cycleCnt_q) == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: if (rstCnt_q == RST_LAST) state_d = ST_RUN;
      ST_RUN:   if (passHit || failHit || timeoutHit) state_d = ST_DONE;
      ST_DONE:  if (restart_i) state_d = ST_RESET;
      default:  state_d = ST_RESET;
    endcase
  end

  always_comb begin
    core_rst_o = 1'b1;
    running_o  = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ST_RUN: begin
        core_rst_o = 1'b0;
        running_o  = 1'b1;
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state; the DONE edge still takes this cycle's counter update.
  always_comb begin
    rstCnt_d     = rstCnt_q;
    cycleCnt_d   = cycleCnt_q;
    instretCnt_d = instretCnt_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    failCode_d   = failCode_q;
    case (state_q)
      ST_RESET: begin
        if (rstCnt_q != RST_LAST) rstCnt_d = rstCnt_q + 8'd1;
      end
      ST_RUN: begin
        if (cycleCnt_q != CNT_MAX) cycleCnt_d = cycleCnt_q + CNT_W'(1);
        if (retire_i && (instretCnt_q != CNT_MAX)) instretCnt_d = instretCnt_q + CNT_W'(1);
        if (passHit) pass_d = 1'b1;
        if (failHit) begin
          fail_d     = 1'b1;
          failCode_d = wr_data_i >> 1;
        end
        if (timeoutHit) timeout_d = 1'b1;
      end
      ST_DONE: begin
        if (restart_i) begin
          rstCnt_d     = '0;
          cycleCnt_d   = '0;
          instretCnt_d = '0;
          pass_d       = 1'b0;
          fail_d       = 1'b0;
          timeout_d    = 1'b0;
          failCode_d   = '0;
        end
      end
      default: rstCnt_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rstCnt_q     <= '0;
      cycleCnt_q   <= '0;
      instretCnt_q <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      failCode_q   <= '0;
    end else begin
      rstCnt_q     <= rstCnt_d;
      cycleCnt_q   <= cycleCnt_d;
      instretCnt_q <= instretCnt_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      failCode_q   <= failCode_d;
    end
  end

  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign timeout_o     = timeout_q;
  assign fail_code_o   = failCode_q;
  assign cycle_cnt_o   = cycleCnt_q;
  assign instret_cnt_o = instretCnt_q;

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter: RST_CYCLES, default 2, number of cycles core_rst_o is held high after entering RESET (legal range 1..255).
REQ-002 Parameter: TIMEOUT_CYCLES, default 100000, number of RUN cycles allowed before a timeout is declared (must be at least 1).
REQ-003 Parameter: ADDR_W, default 32, width of the monitored write address.
REQ-004 Parameter: DATA_W, default 32, width of the monitored write data.
REQ-005 Parameter: CNT_W, default 32, width of the cycle and instret counters.
REQ-006 Parameter: TOHOST_ADDR, default 32'h0000_1000, write address that signals end-of-test.
REQ-007 Port: clk_i, input, 1, single clock; all state updates on the rising edge.
REQ-008 Port: rst_i, input, 1, synchronous active-high reset.
REQ-009 Port: restart_i, input, 1, single-cycle pulse; rerun request, honoured only in DONE.
REQ-010 Port: wr_valid_i, input, 1, core data-memory write strobe.
REQ-011 Port: wr_addr_i, input, ADDR_W, core write address.
REQ-012 Port: wr_data_i, input, DATA_W, core write data.
REQ-013 Port: retire_i, input, 1, one pulse per retired instruction.
REQ-014 Port: core_rst_o, output, 1, reset to the core; synchronous, active-high.
REQ-015 Port: running_o, output, 1, high while in RUN.
REQ-016 Port: done_o, output, 1, high while in DONE.
REQ-017 Port: pass_o, output, 1, sticky in DONE.
REQ-018 Port: fail_o, output, 1, sticky in DONE.
REQ-019 Port: timeout_o, output, 1, sticky in DONE.
REQ-020 Port: fail_code_o, output, DATA_W, holds wr_data_i >> 1 captured on a fail.
REQ-021 Port: cycle_cnt_o, output, CNT_W, count of RUN cycles.
REQ-022 Port: instret_cnt_o, output, CNT_W, count of retire_i pulses seen in RUN.

Function
REQ-023 FSM states SHALL be RESET, RUN and DONE, registered and encoded in 2 bits.
REQ-024 RESET SHALL drive core_rst_o=1, count RST_CYCLES cycles, then go to RUN; the first RUN cycle is the cycle after the count expires.
REQ-025 RUN SHALL drive core_rst_o=0 and running_o=1.
REQ-026 In RUN, cycle_cnt_o SHALL increment by 1 every cycle.
REQ-027 In RUN, instret_cnt_o SHALL increment by 1 on each cycle with retire_i=1.
REQ-028 Both counters SHALL saturate at all-ones and not wrap.
REQ-029 A tohost hit is wr_valid_i=1 and wr_addr_i==TOHOST_ADDR, sampled in RUN only.
REQ-030 Tohost hit with data==1 SHALL set pass_o=1 and go to DONE on the next cycle.
REQ-031 Tohost hit with data>1 SHALL set fail_o=1, load fail_code_o=data>>1, and go to DONE on the next cycle.
REQ-032 Tohost hit with data==0 SHALL be ignored.
REQ-033 Timeout: in RUN, if cycle_cnt_o==TIMEOUT_CYCLES-1 and there is no decisive tohost hit, the block SHALL set timeout_o=1 and go to DONE.
REQ-034 A decisive tohost hit in the same cycle as a timeout SHALL win; timeout_o stays 0.
REQ-035 Exactly one of pass_o, fail_o and timeout_o SHALL be high in DONE.
REQ-036 DONE SHALL drive done_o=1 and core_rst_o=1, freeze both counters, and ignore writes and retire_i.
REQ-037 restart_i in DONE SHALL go to RESET, clear both counters, pass_o, fail_o, timeout_o and fail_code_o, and restart the RST_CYCLES count.
REQ-038 restart_i outside DONE SHALL be ignored.
REQ-039 The counter and tohost update in a cycle SHALL be the one that occurs on the same edge as the DONE transition.
REQ-040 Retire pulses and writes outside RUN SHALL be ignored.

Reset
REQ-041 rst_i=1 SHALL force state RESET and restart the RST_CYCLES count.
REQ-042 rst_i=1 SHALL set core_rst_o=1.
REQ-043 rst_i=1 SHALL clear running_o, done_o, pass_o, fail_o, timeout_o, fail_code_o, cycle_cnt_o and instret_cnt_o to 0.
REQ-044 rst_i asserted mid-RUN or in DONE SHALL abort the run with the same effect as REQ-041 to REQ-043.
REQ-045 rst_i SHALL have priority over restart_i and tohost hits.

Verification
REQ-046 Defaults, rst_i high for 1 cycle then low -> core_rst_o high for exactly 2 cycles after release, then running_o=1, cycle_cnt_o=0,1,2...
REQ-047 In RUN, 5 retire pulses then a write of 1 to 0x1000 -> next cycle done_o=1, pass_o=1, instret_cnt_o=5, and counters frozen.
REQ-048 Write of 0x0000_0007 to 0x1000 -> fail_o=1, fail_code_o=3; a write of 1 to 0x1004 earlier has no effect; a write of 0 to 0x1000 earlier is ignored.
REQ-049 TIMEOUT_CYCLES=10 with no tohost -> timeout_o=1 and done_o=1 after 10 RUN cycles; a variant with a write of 1 to 0x1000 in cycle 9 -> pass_o=1 and timeout_o=0.
REQ-050 In DONE, pulse restart_i -> RESET, all flags and counters 0, core_rst_o high for RST_CYCLES cycles, then RUN.
REQ-051 CNT_W=4 with a long run -> cycle_cnt_o sticks at 15; rst_i mid-RUN -> everything cleared and RESET re-entered.
